// File: rtl/shift_reg_pkg.sv
// Shared types and mode decode for the universal shift register.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_word_cnt.sv
// Shift counter: counts shifts modulo WIDTH and pulses word_valid on each
// completed word. clr (parallel load) restarts the word without a pulse.
module shift_word_cnt #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             word_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      count      <= '0;
      word_valid <= 1'b0;
    end else if (inc) begin
      if (count == LAST) begin
        count      <= '0;
        word_valid <= 1'b1;
      end else begin
        count      <= count + 1'b1;
        word_valid <= 1'b0;
      end
    end else begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / load) with word counter.
// Build option SHIFT_REG_ROTATE_EN adds a rot input that feeds sout back as the serial input.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             d,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] count,
  output logic             word_valid
);

  mode_t mode_e;
  logic  serial_in;

  assign mode_e = mode_t'(mode);

  // sout is always the bit that leaves on the next shift in the selected direction.
  always_comb begin
    sout = q[0];
    if (mode_e == MODE_SHL) sout = q[WIDTH-1];
  end

  always_comb begin
    serial_in = d;
`ifdef SHIFT_REG_ROTATE_EN
    if (rot) serial_in = sout;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else begin
      unique case (mode_e)
        MODE_SHR:  q <= {serial_in, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], serial_in};
        MODE_LOAD: q <= pdata;
        default:   q <= q;
      endcase
    end
  end

  shift_word_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .clr        (mode_e == MODE_LOAD),
    .inc        (is_shift(mode_e)),
    .count      (count),
    .word_valid (word_valid)
  );

endmodule
